// File: rtl/bp_cce_mem_cmd_packer_if.sv
// rtl/bp_cce_mem_cmd_packer_if.sv - mem_cmd stream in / packed block message out bundle
interface bp_cce_mem_cmd_packer_if #(
  parameter int hdr_width_p   = 128,
  parameter int data_width_p  = 64,
  parameter int block_width_p = 512
);
  localparam int beats_lp     = block_width_p / data_width_p;
  localparam int cnt_width_lp = $clog2(beats_lp + 1);

  // Upstream BedRock Stream mem_cmd channel
  logic [hdr_width_p-1:0]   mem_cmd_header_i;
  logic [data_width_p-1:0]  mem_cmd_data_i;
  logic                     mem_cmd_v_i;
  logic                     mem_cmd_ready_and_o;
  logic                     mem_cmd_last_i;

  // Downstream packed message
  logic [hdr_width_p-1:0]   pkt_header_o;
  logic [block_width_p-1:0] pkt_data_o;
  logic [cnt_width_lp-1:0]  pkt_beats_o;
  logic                     pkt_v_o;
  logic                     pkt_ready_and_i;
  logic                     overflow_o;

  // Packer side
  modport slave (
    input  mem_cmd_header_i, mem_cmd_data_i, mem_cmd_v_i, mem_cmd_last_i, pkt_ready_and_i,
    output mem_cmd_ready_and_o, pkt_header_o, pkt_data_o, pkt_beats_o, pkt_v_o, overflow_o
  );

  // Stream producer / packet consumer side
  modport master (
    output mem_cmd_header_i, mem_cmd_data_i, mem_cmd_v_i, mem_cmd_last_i, pkt_ready_and_i,
    input  mem_cmd_ready_and_o, pkt_header_o, pkt_data_o, pkt_beats_o, pkt_v_o, overflow_o
  );
endinterface

// File: rtl/bp_cce_mem_cmd_packer.sv
// rtl/bp_cce_mem_cmd_packer.sv - packs a beat-serial mem_cmd message into one header + block word
module bp_cce_mem_cmd_packer #(
  parameter int hdr_width_p   = 128,
  parameter int data_width_p  = 64,
  parameter int block_width_p = 512
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  bp_cce_mem_cmd_packer_if.slave       io
);
  localparam int beats_lp     = block_width_p / data_width_p;
  localparam int cnt_width_lp = $clog2(beats_lp + 1);

  // A block that is not a whole number of beats cannot be laned cleanly.
  if (block_width_p % data_width_p != 0) begin : g_bad_width
    $error("block_width_p must be a multiple of data_width_p");
  end

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_SEND = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [cnt_width_lp-1:0]  count_q, count_d;
  logic [block_width_p-1:0] data_q, data_d;
  logic [hdr_width_p-1:0]   header_q, header_d;
  logic                     overflow_q, overflow_d;
  logic                     ready_and;
  logic                     beat_accept;

  // Beats are only taken while collecting; reset gates ready so nothing is accepted then.
  assign ready_and   = (state_q == S_FILL) && reset_n_i;
  assign beat_accept = ready_and && io.mem_cmd_v_i;

  // Next-state: collect beats into lanes in FILL, hold the packed message in SEND.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    data_d     = data_q;
    header_d   = header_q;
    overflow_d = overflow_q;

    unique case (state_q)
      S_FILL: begin
        if (beat_accept) begin
          // The header is captured from the first beat only; later beats may carry anything.
          if (count_q == '0) begin
            header_d = io.mem_cmd_header_i;
          end
          if (count_q < cnt_width_lp'(beats_lp)) begin
            for (int k = 0; k < beats_lp; k++) begin
              if (count_q == cnt_width_lp'(k)) begin
                data_d[k*data_width_p +: data_width_p] = io.mem_cmd_data_i;
              end
            end
            count_d = count_q + 1'b1;
          end else begin
            // Excess beats are drained so the upstream never stalls, but flagged.
            overflow_d = 1'b1;
          end
          if (io.mem_cmd_last_i) begin
            state_d = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (io.pkt_ready_and_i) begin
          state_d = S_FILL;
          count_d = '0;
          // Clearing the block keeps unwritten lanes of the next short message at zero.
          data_d  = '0;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q    <= S_FILL;
      count_q    <= '0;
      data_q     <= '0;
      header_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      data_q     <= data_d;
      header_q   <= header_d;
      overflow_q <= overflow_d;
    end
  end

  assign io.mem_cmd_ready_and_o = ready_and;
  assign io.pkt_v_o             = (state_q == S_SEND);
  assign io.pkt_header_o        = header_q;
  assign io.pkt_data_o          = data_q;
  assign io.pkt_beats_o         = count_q;
  assign io.overflow_o          = overflow_q;

endmodule

// File: tb/tb_bp_cce_mem_cmd_packer.sv
// tb/tb_bp_cce_mem_cmd_packer.sv - directed self-checking bench for bp_cce_mem_cmd_packer
module tb_bp_cce_mem_cmd_packer;
  localparam int HW = 128;
  localparam int DW = 64;
  localparam int BW = 512;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  bp_cce_mem_cmd_packer_if #(.hdr_width_p(HW), .data_width_p(DW), .block_width_p(BW)) io ();

  bp_cce_mem_cmd_packer #(.hdr_width_p(HW), .data_width_p(DW), .block_width_p(BW)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .io        (io.slave)
  );

  always #5 clk = ~clk;

  localparam logic [HW-1:0] H1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [HW-1:0] H2 = 128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000_1234;
  localparam logic [HW-1:0] H3 = 128'h0BAD_F00D_0000_0000_0000_0000_0000_0042;

  logic [BW-1:0] exp_data;
  logic [BW-1:0] held_data;

  task automatic check_eq(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Next beat edge plus settle time; all sampling happens here, away from posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat and wait (bounded) until it is accepted.
  task automatic send_beat(input logic [HW-1:0] hdr, input logic [DW-1:0] d, input logic last);
    int n;
    io.mem_cmd_header_i = hdr;
    io.mem_cmd_data_i   = d;
    io.mem_cmd_last_i   = last;
    io.mem_cmd_v_i      = 1'b1;
    n = 0;
    while (io.mem_cmd_ready_and_o !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) check_eq("beat_ready_timeout", 0, 1);
    step();
    io.mem_cmd_v_i    = 1'b0;
    io.mem_cmd_last_i = 1'b0;
  endtask

  // Complete the output handshake and confirm the packer returns to collecting.
  task automatic take_pkt(input string tag);
    io.pkt_ready_and_i = 1'b1;
    step();
    io.pkt_ready_and_i = 1'b0;
    check_eq({tag, "_v_after"}, io.pkt_v_o, 0);
    check_eq({tag, "_rdy_after"}, io.mem_cmd_ready_and_o, 1);
  endtask

  initial begin
    io.mem_cmd_header_i = '0;
    io.mem_cmd_data_i   = '0;
    io.mem_cmd_v_i      = 1'b0;
    io.mem_cmd_last_i   = 1'b0;
    io.pkt_ready_and_i  = 1'b0;

    // Reset state
    step();
    check_eq("rst_rdy", io.mem_cmd_ready_and_o, 0);
    step();
    reset_n = 1'b1;
    step();
    check_eq("rst_v", io.pkt_v_o, 0);
    check_eq("rst_ovf", io.overflow_o, 0);
    check_eq("rst_beats", io.pkt_beats_o, 0);
    check_eq("rst_hdr", io.pkt_header_o, 0);
    check_eq("rst_data", io.pkt_data_o, 0);
    check_eq("rst_rdy_after", io.mem_cmd_ready_and_o, 1);

    // 1: eight-beat write, beat k carries k
    exp_data = '0;
    for (int k = 0; k < 8; k++) begin
      check_eq("t1_v_during", io.pkt_v_o, 0);
      send_beat(H1, 64'(k), k == 7);
      exp_data[k*DW +: DW] = 64'(k);
    end
    check_eq("t1_v", io.pkt_v_o, 1);
    check_eq("t1_rdy", io.mem_cmd_ready_and_o, 0);
    check_eq("t1_data", io.pkt_data_o, exp_data);
    check_eq("t1_beats", io.pkt_beats_o, 8);
    check_eq("t1_hdr", io.pkt_header_o, H1);
    take_pkt("t1");

    // 2: single-beat read command
    send_beat(H2, 64'hDEAD, 1'b1);
    exp_data = '0;
    exp_data[DW-1:0] = 64'hDEAD;
    check_eq("t2_v", io.pkt_v_o, 1);
    check_eq("t2_data", io.pkt_data_o, exp_data);
    check_eq("t2_beats", io.pkt_beats_o, 1);
    check_eq("t2_hdr", io.pkt_header_o, H2);

    // 3: hold the consumer off for five cycles
    held_data = exp_data;
    for (int c = 0; c < 5; c++) begin
      io.mem_cmd_v_i = 1'b1;
      step();
      check_eq("t3_v_hold", io.pkt_v_o, 1);
      check_eq("t3_rdy_hold", io.mem_cmd_ready_and_o, 0);
      check_eq("t3_data_hold", io.pkt_data_o, held_data);
      check_eq("t3_beats_hold", io.pkt_beats_o, 1);
    end
    io.mem_cmd_v_i = 1'b0;
    take_pkt("t3");

    // 5: ten-beat message overflows the block
    exp_data = '0;
    for (int k = 0; k < 10; k++) begin
      send_beat(H3, 64'h100 + 64'(k), k == 9);
      if (k < 8) exp_data[k*DW +: DW] = 64'h100 + 64'(k);
    end
    check_eq("t5_v", io.pkt_v_o, 1);
    check_eq("t5_data", io.pkt_data_o, exp_data);
    check_eq("t5_beats", io.pkt_beats_o, 8);
    check_eq("t5_ovf", io.overflow_o, 1);
    take_pkt("t5");

    // 4: header changes after the first beat
    send_beat(H1, 64'h55, 1'b0);
    send_beat(H2, 64'h66, 1'b0);
    send_beat(H2, 64'h77, 1'b1);
    exp_data = '0;
    exp_data[0*DW +: DW] = 64'h55;
    exp_data[1*DW +: DW] = 64'h66;
    exp_data[2*DW +: DW] = 64'h77;
    check_eq("t4_hdr", io.pkt_header_o, H1);
    check_eq("t4_data", io.pkt_data_o, exp_data);
    check_eq("t4_beats", io.pkt_beats_o, 3);
    check_eq("t4_ovf_sticky", io.overflow_o, 1);
    take_pkt("t4");
    check_eq("t4_ovf_sticky2", io.overflow_o, 1);

    // 6: reset in mid-message, then a clean two-beat message
    for (int k = 0; k < 3; k++) send_beat(H3, 64'hF0 + 64'(k), 1'b0);
    reset_n = 1'b0;
    #1;
    check_eq("t6_rdy_in_rst", io.mem_cmd_ready_and_o, 0);
    step();
    reset_n = 1'b1;
    step();
    check_eq("t6_v_post_rst", io.pkt_v_o, 0);
    check_eq("t6_ovf_post_rst", io.overflow_o, 0);
    check_eq("t6_beats_post_rst", io.pkt_beats_o, 0);
    send_beat(H2, 64'hA0, 1'b0);
    check_eq("t6_v_mid", io.pkt_v_o, 0);
    send_beat(H2, 64'hA1, 1'b1);
    exp_data = '0;
    exp_data[0*DW +: DW] = 64'hA0;
    exp_data[1*DW +: DW] = 64'hA1;
    check_eq("t6_v", io.pkt_v_o, 1);
    check_eq("t6_data", io.pkt_data_o, exp_data);
    check_eq("t6_beats", io.pkt_beats_o, 2);
    check_eq("t6_hdr", io.pkt_header_o, H2);
    check_eq("t6_ovf", io.overflow_o, 0);
    take_pkt("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
